// File: rtl/wb_stage_if.sv
// Retiring-op bus from the memory stage into writeback.
// The memory stage is the master; writeback is the slave and returns in_ready.
interface wb_stage_if #(
    parameter int DATA_W  = 24,
    parameter int RADDR_W = 4
);
    logic               in_valid;
    logic               in_ready;
    logic [RADDR_W-1:0] in_rd;
    logic               in_wen;
    logic               in_is_load;
    logic [DATA_W-1:0]  in_alu_result;

    modport master (
        output in_valid, in_rd, in_wen, in_is_load, in_alu_result,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_rd, in_wen, in_is_load, in_alu_result,
        output in_ready
    );
endinterface

// File: rtl/wb_stage.sv
// Writeback stage: retires ALU ops directly and waits for load data,
// with a bounded wait, before driving the regfile write port.
module wb_stage #(
    parameter int DATA_W     = 24,
    parameter int RADDR_W    = 4,
    parameter int LD_TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    wb_stage_if.slave          up,
    input  logic               ld_rsp_valid,
    input  logic [DATA_W-1:0]  ld_rsp_data,
    output logic               reg_write_en,
    output logic [RADDR_W-1:0] reg_write_dest,
    output logic [DATA_W-1:0]  reg_write_data,
    output logic               ld_pending,
    output logic [RADDR_W-1:0] ld_pending_rd,
    output logic               ld_timeout
);
    typedef enum logic [0:0] {IDLE = 1'b0, WAIT_LD = 1'b1} state_t;

    // The counter saturates one short of LD_TIMEOUT: the edge that would reach it abandons the load.
    localparam logic [15:0] CNT_LAST = 16'(LD_TIMEOUT - 1);

    state_t             state_r;
    logic [15:0]        cnt_r;
    logic               ld_wen_r;
    logic               reg_write_en_r;
    logic [RADDR_W-1:0] reg_write_dest_r;
    logic [DATA_W-1:0]  reg_write_data_r;
    logic               ld_pending_r;
    logic [RADDR_W-1:0] ld_pending_rd_r;
    logic               ld_timeout_r;
    logic               accept_s;

    // Register 0 is hardwired zero, so writes to it are dropped.
    function automatic logic write_qual(input logic wen, input logic [RADDR_W-1:0] rd);
        return wen && (rd != {RADDR_W{1'b0}});
    endfunction

    assign up.in_ready = (state_r == IDLE);

    // Handshake transfer decode.
    always_comb begin
        accept_s = 1'b0;
        if (up.in_valid && (state_r == IDLE)) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
    end

    // Writeback FSM with registered regfile port and hazard outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r          <= IDLE;
            cnt_r            <= 16'd0;
            ld_wen_r         <= 1'b0;
            reg_write_en_r   <= 1'b0;
            reg_write_dest_r <= {RADDR_W{1'b0}};
            reg_write_data_r <= {DATA_W{1'b0}};
            ld_pending_r     <= 1'b0;
            ld_pending_rd_r  <= {RADDR_W{1'b0}};
            ld_timeout_r     <= 1'b0;
        end else begin
            reg_write_en_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        if (up.in_is_load) begin
                            state_r         <= WAIT_LD;
                            cnt_r           <= 16'd0;
                            ld_wen_r        <= up.in_wen;
                            ld_pending_r    <= 1'b1;
                            ld_pending_rd_r <= up.in_rd;
                        end else if (write_qual(up.in_wen, up.in_rd)) begin
                            reg_write_en_r   <= 1'b1;
                            reg_write_dest_r <= up.in_rd;
                            reg_write_data_r <= up.in_alu_result;
                        end
                    end
                end
                WAIT_LD: begin
                    if (ld_rsp_valid) begin
                        state_r         <= IDLE;
                        ld_pending_r    <= 1'b0;
                        ld_pending_rd_r <= {RADDR_W{1'b0}};
                        if (write_qual(ld_wen_r, ld_pending_rd_r)) begin
                            reg_write_en_r   <= 1'b1;
                            reg_write_dest_r <= ld_pending_rd_r;
                            reg_write_data_r <= ld_rsp_data;
                        end
                    end else if (cnt_r >= CNT_LAST) begin
                        state_r         <= IDLE;
                        ld_pending_r    <= 1'b0;
                        ld_pending_rd_r <= {RADDR_W{1'b0}};
                        ld_timeout_r    <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + 16'd1;
                    end
                end
                default: begin
                    state_r         <= IDLE;
                    ld_pending_r    <= 1'b0;
                    ld_pending_rd_r <= {RADDR_W{1'b0}};
                end
            endcase
        end
    end

    assign reg_write_en   = reg_write_en_r;
    assign reg_write_dest = reg_write_dest_r;
    assign reg_write_data = reg_write_data_r;
    assign ld_pending     = ld_pending_r;
    assign ld_pending_rd  = ld_pending_rd_r;
    assign ld_timeout     = ld_timeout_r;
endmodule
